// File: rtl/pipeline_pkg.sv
// Shared types and flush masks for the fetch front end of the 5-stage core.
package pipeline_pkg;

  typedef enum logic [1:0] {FILL, RUN, HALT} fetch_state_t;

  // Masks over rst_p_out[4:1]: bit k clears the stage-k register.
  localparam logic [3:0] FLUSH_NONE      = 4'b0000;
  localparam logic [3:0] FLUSH_FILL      = 4'b0001;
  localparam logic [3:0] FLUSH_BUBBLE_S2 = 4'b0010;
  localparam logic [3:0] FLUSH_HALT      = 4'b0011;
  localparam logic [3:0] FLUSH_REDIRECT  = 4'b0111;
  localparam logic [3:0] FLUSH_ALL       = 4'b1111;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the stage-2 destination and the stage-1 register fields.
module hazard_detect #(
  parameter int REG_W = 3
) (
  input  logic             loads,
  input  logic             write,
  input  logic [REG_W-1:0] writenum,
  input  logic [REG_W-1:0] num_rm,
  input  logic [REG_W-1:0] num_rn,
  input  logic [REG_W-1:0] num_rd,
  output logic             stall
);

  // Rd is compared too even when it is only a destination; a false stall is harmless.
  assign stall = loads & write &
                 ((writenum == num_rm) | (writenum == num_rn) | (writenum == num_rd));

endmodule

// File: rtl/pipeline_fetch_ctrl.sv
// PC holder and fetch sequencer: drives the synchronous imem, stage-1 enable and stage flushes.
module pipeline_fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] IR_out,
  output logic [7:0]  PC_out,
  output logic        update_1out,
  output logic [4:1]  rst_p_out,
  input  logic        loads_2in,
  input  logic        write_2in,
  input  logic [2:0]  writenum_2in,
  input  logic [2:0]  num_Rm_1in,
  input  logic [2:0]  num_Rn_1in,
  input  logic [2:0]  num_Rd_1in,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic [15:0] stall_count
);

  fetch_state_t state, state_nxt;
  logic [7:0]   pc, pc_next;
  logic [15:0]  stall_cnt;
  logic         stall, stall_take;

  hazard_detect #(.REG_W(3)) u_hazard (
    .loads    (loads_2in),
    .write    (write_2in),
    .writenum (writenum_2in),
    .num_rm   (num_Rm_1in),
    .num_rn   (num_Rn_1in),
    .num_rd   (num_Rd_1in),
    .stall    (stall)
  );

  always_comb begin
    state_nxt   = state;
    pc_next     = pc;
    update_1out = 1'b0;
    rst_p_out   = FLUSH_NONE;
    halted      = 1'b0;
    stall_take  = 1'b0;
    if (rst) begin
      // Hold the fetch address at the reset vector so the bus is quiet while in reset.
      pc_next   = RESET_PC;
      rst_p_out = FLUSH_ALL;
      state_nxt = FILL;
    end else begin
      unique case (state)
        FILL: begin
          update_1out = 1'b1;
          rst_p_out   = FLUSH_FILL;
          state_nxt   = RUN;
        end
        RUN: begin
          if (halt_req) begin
            rst_p_out = FLUSH_REDIRECT;
            state_nxt = HALT;
          end else if (redirect_valid) begin
            pc_next     = redirect_pc;
            update_1out = 1'b1;
            rst_p_out   = FLUSH_REDIRECT;
          end else if (stall) begin
            rst_p_out  = FLUSH_BUBBLE_S2;
            stall_take = 1'b1;
          end else begin
            pc_next     = pc + 8'd1;
            update_1out = 1'b1;
          end
        end
        HALT: begin
          rst_p_out = FLUSH_HALT;
          halted    = 1'b1;
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= FILL;
      stall_cnt <= 16'd0;
    end else begin
      pc    <= pc_next;
      state <= state_nxt;
      if (stall_take) stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  // pc always names the word now on imem_rdata, since that word was fetched from last cycle's pc_next.
  assign imem_addr   = pc_next;
  assign IR_out      = imem_rdata;
  assign PC_out      = pc;
  assign stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// Directed plus randomized bench for pipeline_fetch_ctrl against a cycle-level behavioural model.
module tb_pipeline_fetch_ctrl;

  localparam logic [7:0] RPC = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] IR_out;
  logic [7:0]  PC_out;
  logic        update_1out;
  logic [4:1]  rst_p_out;
  logic        loads_2in, write_2in;
  logic [2:0]  writenum_2in, num_Rm_1in, num_Rn_1in, num_Rd_1in;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt_req;
  logic        halted;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipeline_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .IR_out(IR_out), .PC_out(PC_out), .update_1out(update_1out), .rst_p_out(rst_p_out),
    .loads_2in(loads_2in), .write_2in(write_2in), .writenum_2in(writenum_2in),
    .num_Rm_1in(num_Rm_1in), .num_Rn_1in(num_Rn_1in), .num_Rd_1in(num_Rd_1in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(halted), .stall_count(stall_count)
  );

  // Synchronous-read instruction memory, one-cycle latency.
  logic [15:0] mem [256];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int checks = 0;
  int failures = 0;

  // Model: phase 0 = filling, 1 = running, 2 = halted.
  int         m_phase;
  logic [7:0] m_pc;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input bit do_chk);
    bit         hz;
    logic [7:0] e_addr;
    logic       e_upd, e_hlt;
    logic [3:0] e_rp;
    @(negedge clk);
    hz = loads_2in && write_2in && (writenum_2in == num_Rm_1in ||
         writenum_2in == num_Rn_1in || writenum_2in == num_Rd_1in);
    e_addr = m_pc; e_upd = 1'b0; e_rp = 4'b0000; e_hlt = 1'b0;
    if (rst)                e_rp = 4'b1111;
    else if (m_phase == 0) begin e_upd = 1'b1; e_rp = 4'b0001; end
    else if (m_phase == 2) begin e_rp = 4'b0011; e_hlt = 1'b1; end
    else if (halt_req)      e_rp = 4'b0111;
    else if (redirect_valid) begin e_addr = redirect_pc; e_upd = 1'b1; e_rp = 4'b0111; end
    else if (hz)            e_rp = 4'b0010;
    else begin e_addr = m_pc + 8'd1; e_upd = 1'b1; end
    if (do_chk) begin
      chk("update_1out", {31'd0, update_1out}, {31'd0, e_upd});
      chk("rst_p_out", {28'd0, rst_p_out}, {28'd0, e_rp});
      chk("halted", {31'd0, halted}, {31'd0, e_hlt});
      if (!rst) begin
        chk("imem_addr", {24'd0, imem_addr}, {24'd0, e_addr});
        chk("stall_count", {16'd0, stall_count}, m_cnt);
        if (m_phase != 0) begin
          chk("PC_out", {24'd0, PC_out}, {24'd0, m_pc});
          chk("IR_out", {16'd0, IR_out}, {16'd0, mem[m_pc]});
        end
      end
    end
    @(posedge clk);
    if (rst) begin m_pc = RPC; m_phase = 0; m_cnt = 0; end
    else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      if (halt_req)            m_phase = 2;
      else if (redirect_valid) m_pc = redirect_pc;
      else if (hz)             begin if (m_cnt < 65535) m_cnt++; end
      else                     m_pc = m_pc + 8'd1;
    end
    #1;
  endtask

  task automatic quiet();
    loads_2in = 0; write_2in = 0; writenum_2in = 0; num_Rm_1in = 0; num_Rn_1in = 0;
    num_Rd_1in = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
  endtask

  task automatic set_hazard();
    loads_2in = 1; write_2in = 1; writenum_2in = 3; num_Rn_1in = 3; num_Rm_1in = 0; num_Rd_1in = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    m_phase = 0; m_pc = RPC; m_cnt = 0;
    quiet();
    rst = 1;
    tick(1); tick(1);
    rst = 0;
    tick(1);            // FILL, address 10
    tick(1); tick(1);   // 11, 12 with IR for 10, 11

    set_hazard();
    tick(1);
    quiet();
    chk("stall_cnt_one", {16'd0, stall_count}, 32'd1);
    tick(1); tick(1);

    set_hazard(); redirect_valid = 1; redirect_pc = 8'h40;
    tick(1);
    quiet();
    tick(1);
    chk("redirect_no_count", {16'd0, stall_count}, 32'd1);

    redirect_valid = 1; redirect_pc = 8'hFE;
    tick(1);
    quiet();
    tick(1); tick(1); tick(1);   // FE -> FF -> 00 wrap

    for (int i = 0; i < 800; i++) begin
      rst            = ($urandom_range(0, 39) == 0);
      halt_req       = ($urandom_range(0, 29) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = 8'($urandom);
      loads_2in      = 1'($urandom);
      write_2in      = 1'($urandom);
      writenum_2in   = 3'($urandom);
      num_Rm_1in     = 3'($urandom);
      num_Rn_1in     = 3'($urandom);
      num_Rd_1in     = 3'($urandom);
      tick(1);
    end

    quiet();
    rst = 1; tick(1);
    rst = 0; tick(1); tick(1); tick(1);
    halt_req = 1; tick(1);
    halt_req = 0; redirect_valid = 1; redirect_pc = 8'h55;
    tick(1); tick(1); tick(1);
    chk("halted_hold", {31'd0, halted}, 32'd1);
    quiet();
    tick(1); tick(1);
    rst = 1; tick(1);
    rst = 0; tick(1);
    chk("halt_exit", {31'd0, halted}, 32'd0);

    set_hazard();
    for (int i = 0; i < 65540; i++) tick(0);
    tick(1);
    chk("stall_sat", {16'd0, stall_count}, 32'h0000FFFF);
    quiet();
    tick(1); tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_fetch_ctrl.md
# pipeline_fetch_ctrl

Front end of the 5-stage core, driving the pipeline's instruction, PC, stage-1 update and per-stage flush inputs. It holds the PC and addresses a synchronous-read instruction memory. It detects load-use hazards from the stage-1/stage-2 register fields and inserts stalls and bubbles. It applies stage-3 redirects and halts by squashing younger stages.

## Interface
- `RESET_PC`, default 8'h00: PC loaded on reset.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `imem_addr`, output, 8: instruction memory read address, combinational.
- `imem_rdata`, input, 16: instruction word for the previous cycle's `imem_addr`, one-cycle latency.
- `IR_out`, output, 16: instruction presented to decode; equals `imem_rdata`.
- `PC_out`, output, 8: address of the instruction on `IR_out`.
- `update_1out`, output, 1: stage-1 register enable.
- `rst_p_out`, output, 4 (`[4:1]`): per-stage bubble/squash; bit *k* clears the stage-*k* register at the next edge.
- `loads_2in`, input, 1: stage 2 holds a load.
- `write_2in`, input, 1: stage 2 writes a register.
- `writenum_2in`, input, 3: stage-2 destination register.
- `num_Rm_1in`, `num_Rn_1in`, `num_Rd_1in`, inputs, 3 each: stage-1 register fields.
- `redirect_valid`, input, 1: stage-3 control-flow change.
- `redirect_pc`, input, 8: redirect target.
- `halt_req`, input, 1: stage-3 HALT.
- `halted`, output, 1: high in HALT state.
- `stall_count`, output, 16: saturating count of stall cycles.

## Operation
- State register has three states: FILL, RUN, HALT. Register `pc`; `pc_next` drives `imem_addr`.
- Reset: `pc`←RESET_PC, state←FILL, `stall_count`←0. During the reset cycle the outputs are `update_1out`=0, `rst_p_out`=4'b1111, `halted`=0.
- FILL (one cycle after reset): `imem_rdata` is not yet valid.
  - `rst_p_out[1]`=1, `update_1out`=1.
  - `pc_next`=`pc`, so the word for RESET_PC arrives next cycle.
  - Next state RUN.
- In RUN, priority is halt_req > redirect_valid > stall > normal.
- Stall condition: `loads_2in & write_2in & (writenum_2in` equals any of `num_Rm_1in`, `num_Rn_1in`, `num_Rd_1in`). The compare is conservative; false stalls are permitted.
- Normal: `pc_next`=`pc`+1 (8-bit, 8'hFF wraps to 8'h00), `update_1out`=1, `rst_p_out`=0.
- Stall: `pc_next`=`pc` (the word is re-read and `IR_out` is stable), `update_1out`=0, `rst_p_out`=4'b0010 (bubble into S2), `stall_count`+1 saturating at 16'hFFFF.
- Redirect: `pc_next`=`redirect_pc`, `update_1out`=1, `rst_p_out`=4'b0111 (squash S1–S3 captures). Any simultaneous stall is ignored.
- Halt: `rst_p_out`=4'b0111, `update_1out`=0, `pc` frozen, next state HALT.
- HALT: `update_1out`=0, `rst_p_out`=4'b0011, `halted`=1, `pc_next`=`pc`. Only `rst` exits.
- `redirect_valid` or `halt_req` during FILL: ignored.

## Timing
- Fetch latency: an address issued in cycle *n* gives `IR_out`/`PC_out` in cycle *n*+1. There is no bubble after a redirect.
- A load-use hazard costs exactly one stall cycle. The hazard clears the next cycle because the load has moved to S3 and S2 holds a bubble.
- `rst` asserted mid-stall, mid-redirect or in HALT takes effect at the next edge and overrides all inputs.
- `stall_count` increments on the same edge where the stall is applied.

## Structure
- Package `pipeline_pkg`:
  - `fetch_state_t` enum {FILL, RUN, HALT}.
  - Flush-mask constants `FLUSH_NONE`=4'b0000, `FLUSH_BUBBLE_S2`=4'b0010, `FLUSH_REDIRECT`=4'b0111, `FLUSH_HALT`=4'b0011.
- Sub-module `hazard_detect`: combinational load-use compare producing `stall`. It is reused later by a second-issue path.

## Test plan
- Reset with RESET_PC=8'h10, `rst` held 2 cycles then released.
  - `imem_addr`: 10 (FILL), 11, 12.
  - `IR_out` valid for PC 10 one cycle after FILL.
  - `rst_p_out[1]`=1 only during FILL.
- `loads_2in`=1, `write_2in`=1, `writenum_2in`=3, `num_Rn_1in`=3 for one cycle:
  - `update_1out`=0, `rst_p_out`=0010, `imem_addr` repeats.
  - `stall_count` goes 0→1.
  - The next cycle resumes with PC+1.
- Stall condition and `redirect_valid` with `redirect_pc`=8'h40 in the same cycle:
  - `rst_p_out`=0111, `update_1out`=1, `imem_addr`=40.
  - `PC_out`=40 next cycle; `stall_count` unchanged.
- `pc` at 8'hFF in normal flow: next `imem_addr`=8'h00.
- `halt_req` pulse:
  - `rst_p_out`=0111 that cycle, then 0011 with `halted`=1 indefinitely.
  - `redirect_valid` is ignored while halted.
  - `rst` returns to FILL.
- Stall held for 70000 cycles: `stall_count` saturates at 16'hFFFF.
